// File: rtl/multisim_client_quasi_static_push_multi.sv
// Generic FIFO: registered storage, head word visible combinationally.
// Latency: one cycle from push to dout; level updates on the same edge.
// Backpressure: caller must not push when full unless popping in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    assign dout = mem[rd_ptr];
endmodule

// Push-client endpoint: ready whenever a runtime directory and a server are named.
// Latency: combinational ready. Backpressure: ready drops while no server is named.
module multisim_client_push #(
    parameter string SERVER_RUNTIME_DIRECTORY = "../output_top",
    parameter int    DATA_WIDTH               = 64
) (
    input  string                 server_name,
    input  logic                  data_vld,
    output logic                  data_rdy,
    input  logic [DATA_WIDTH-1:0] data
);
    logic unused_sink;

    always_comb begin
        data_rdy = (SERVER_RUNTIME_DIRECTORY != "") && (server_name != "");
    end

    // The word itself is consumed by the server side of the partition.
    assign unused_sink = ^{data_vld, data};
endmodule

// Forwards value changes on NUM_CHANNELS quasi-static buses as {channel, value} words.
// Latency: change sampled at edge k, enqueued at k+1 (empty FIFO, no contention).
// Backpressure: FIFO fills, then pending registers coalesce (latest value wins, counted).
module multisim_client_quasi_static_push_multi #(
    parameter string SERVER_RUNTIME_DIRECTORY = "../output_top",
    parameter int    DATA_WIDTH               = 64,
    parameter int    NUM_CHANNELS             = 4,
    parameter int    FIFO_DEPTH               = 8,
    localparam int   CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int   PUSH_W = CH_W + DATA_WIDTH,
    localparam int   LVL_W  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  string                              server_name,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
    output logic                               push_vld,
    output logic                               push_rdy,
    output logic [PUSH_W-1:0]                  push_data,
    output logic [LVL_W-1:0]                   fifo_level,
    output logic [31:0]                        coalesce_cnt
);
    logic                    snap;
    logic [DATA_WIDTH-1:0]   prev     [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   pend_val [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] pending;
    logic [NUM_CHANNELS-1:0] changed;
    logic [NUM_CHANNELS-1:0] coal_hit;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         sel;
    logic [CH_W-1:0]         next_rr;
    logic                    found;
    logic                    enq;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   head_val;
    logic [32:0]             coal_sum;
    logic [31:0]             coal_next;

    always_comb begin
        changed = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            changed[c] = !snap && (data[c*DATA_WIDTH +: DATA_WIDTH] !== prev[c]);
        end
    end

    // Round-robin: the outer offset loop gives priority starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (!found && pending[c] && (c == (int'(rr_ptr) + i) % NUM_CHANNELS)) begin
                    found = 1'b1;
                    sel   = CH_W'(c);
                end
            end
        end
    end

    always_comb begin
        head_val = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (sel == CH_W'(c)) begin
                head_val = pend_val[c];
            end
        end
    end

    assign next_rr  = (int'(sel) == NUM_CHANNELS - 1) ? '0 : sel + CH_W'(1);
    assign push_vld = (fifo_level != '0);
    assign pop      = push_vld && push_rdy;
    assign enq      = !snap && found && ((fifo_level < LVL_W'(FIFO_DEPTH)) || pop);

    // A channel enqueued this cycle is not a coalesce even if it changes again.
    always_comb begin
        coal_hit = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            coal_hit[c] = changed[c] && pending[c] && !(enq && (sel == CH_W'(c)));
        end
        coal_sum  = {1'b0, coalesce_cnt} + 33'($countones(coal_hit));
        coal_next = coal_sum[32] ? '1 : coal_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap         <= 1'b1;
            rr_ptr       <= '0;
            pending      <= '0;
            coalesce_cnt <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                prev[c]     <= '0;
                pend_val[c] <= '0;
            end
        end else if (snap) begin
            snap    <= 1'b0;
            pending <= '1;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                prev[c]     <= data[c*DATA_WIDTH +: DATA_WIDTH];
                pend_val[c] <= data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (changed[c]) begin
                    prev[c]     <= data[c*DATA_WIDTH +: DATA_WIDTH];
                    pend_val[c] <= data[c*DATA_WIDTH +: DATA_WIDTH];
                    pending[c]  <= 1'b1;
                end else if (enq && (sel == CH_W'(c))) begin
                    pending[c]  <= 1'b0;
                end
            end
            if (enq) begin
                rr_ptr <= next_rr;
            end
            coalesce_cnt <= coal_next;
        end
    end

    fifo #(
        .W     (PUSH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (enq),
        .din   ({sel, head_val}),
        .pop   (pop),
        .dout  (push_data),
        .level (fifo_level)
    );

    multisim_client_push #(
        .SERVER_RUNTIME_DIRECTORY (SERVER_RUNTIME_DIRECTORY),
        .DATA_WIDTH               (PUSH_W)
    ) u_push (
        .server_name (server_name),
        .data_vld    (push_vld),
        .data_rdy    (push_rdy),
        .data        (push_data)
    );
endmodule
